// File: rtl/mips_rtype_sequencer_if.sv
// mips_rtype_sequencer_if: host load stream and result stream of the R-type sequencer
interface mips_rtype_sequencer_if #(
   parameter int IDX_W = 4
);
   logic             load_valid;
   logic             load_ready;
   logic [31:0]      load_data;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;
   logic [IDX_W-1:0] res_tag;
   modport master (
      output load_valid, load_data, res_ready,
      input  load_ready, res_valid, res_data, res_tag
   );
   modport slave (
      input  load_valid, load_data, res_ready,
      output load_ready, res_valid, res_data, res_tag
   );
endinterface

// File: rtl/mips_rtype_sequencer.sv
// mips_rtype_sequencer: buffers R-type words, issues them to mips_core and streams tagged results
module mips_rtype_sequencer #(
   parameter int DEPTH  = 16,
   parameter int SETTLE = 1,
   parameter int IDX_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mips_rtype_sequencer_if.slave bus,
   input  logic                 start,
   input  logic                 abort,
   output logic [31:0]          core_instr,
   input  logic [31:0]          core_result,
   output logic                 busy,
   output logic                 done,
   output logic                 err_illegal,
   output logic [IDX_W:0]       exec_count
);
   localparam int CW = $clog2(SETTLE + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
   state_t           state;
   logic [31:0]      mem [DEPTH];
   logic [IDX_W-1:0] wr_ptr, rd_ptr, rd_nxt, res_tag;
   logic [IDX_W:0]   fill;
   logic [CW-1:0]    cnt;
   logic [31:0]      res_data, cur, nxt;
   logic             res_valid, load_ok, last, illegal, hs;
   assign rd_nxt         = rd_ptr + 1'b1;
   assign cur            = mem[rd_ptr];
   assign nxt            = mem[rd_nxt];
   assign last           = {1'b0, rd_ptr} == fill - 1'b1;
   assign illegal        = |cur[31:26];
   assign hs             = res_valid & bus.res_ready;
   assign bus.load_ready = state == IDLE && !fill[IDX_W];
   assign load_ok        = bus.load_valid && bus.load_ready && !abort;
   assign bus.res_valid  = res_valid;
   assign bus.res_data   = res_data;
   assign bus.res_tag    = res_tag;
   assign busy           = state != IDLE;
   always_ff @(posedge clk)
      if (load_ok) mem[wr_ptr] <= bus.load_data;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill        <= '0;
         cnt         <= '0;
         core_instr  <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_tag     <= '0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
         exec_count  <= '0;
      end else if (abort) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
         cnt        <= '0;
         core_instr <= '0;
         res_valid  <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load_ok) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  fill   <= fill + 1'b1;
               end
               if (start) begin
                  exec_count <= '0;
                  rd_ptr     <= '0;
                  cnt        <= '0;
                  if (|fill || load_ok) begin
                     state       <= ISSUE;
                     err_illegal <= 1'b0;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (illegal) begin
                  err_illegal <= 1'b1;
                  cnt         <= '0;
                  if (last) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     core_instr <= '0;
                  end else rd_ptr <= rd_nxt;
               end else begin
                  core_instr <= cur;
                  // cnt counts cycles core_instr has already been held stable
                  if (cnt == CW'(SETTLE)) begin
                     res_valid <= 1'b1;
                     res_data  <= core_result;
                     res_tag   <= rd_ptr;
                     cnt       <= '0;
                     state     <= CAPTURE;
                  end else cnt <= cnt + 1'b1;
               end
            end
            CAPTURE: begin
               if (hs) begin
                  res_valid  <= 1'b0;
                  exec_count <= exec_count + 1'b1;
                  if (last) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     core_instr <= '0;
                  end else begin
                     // preload the next word on the handshake so results keep a SETTLE+1 cadence
                     rd_ptr     <= rd_nxt;
                     core_instr <= nxt;
                     cnt        <= CW'(1);
                     state      <= ISSUE;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               fill       <= '0;
               wr_ptr     <= '0;
               core_instr <= '0;
            end
         endcase
      end
   end
endmodule
